// File: rtl/multi_square_wave_gen_if.sv
// Configuration port bundle for multi_square_wave_gen.
// The master drives a write request and the slave answers with cfg_ready.
interface multi_square_wave_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 24
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CW-1:0]        cfg_chan;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [CNT_WIDTH-1:0] cfg_high;

  modport master (
    output cfg_valid, cfg_chan, cfg_period, cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_period, cfg_high,
    output cfg_ready
  );
endinterface

// File: rtl/multi_square_wave_gen.sv
// Multi-channel programmable square/PWM wave generator.
// Each channel runs its own period counter; new period/high values are
// staged in shadow registers and applied only at the channel's period
// boundary (or immediately when the channel is disabled), so a period in
// progress always completes with its old values.
// Optional feature macro: WAVE_DUTY_EN (arbitrary high time from cfg_high).
// Without it the high time is period>>1 and cfg_high is ignored.
module multi_square_wave_gen #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 24,
  parameter int DEFAULT_PERIOD = 12000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     ch_en,
  multi_square_wave_gen_if.slave  cfg,
  output logic [CHANNELS-1:0]     wave_out,
  output logic [CHANNELS-1:0]     period_tick
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_WIDTH-1:0] DEF_P = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] DEF_H = CNT_WIDTH'(DEFAULT_PERIOD >> 1);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO   = CNT_WIDTH'(2);

  logic [CHANNELS-1:0]  sel;
  logic [CHANNELS-1:0]  pending;
  logic [CNT_WIDTH-1:0] h_cfg;

`ifdef WAVE_DUTY_EN
  assign h_cfg = cfg.cfg_high;
`else
  // Fixed 50% duty: the low half takes the extra cycle for odd periods.
  assign h_cfg = cfg.cfg_period >> 1;
  logic unused_cfg_high;
  assign unused_cfg_high = ^cfg.cfg_high;
`endif

  // Ready is low only while the addressed channel still holds an unapplied
  // write; an out-of-range channel matches no sel bit and so always accepts.
  assign cfg.cfg_ready = ~|(sel & pending);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic [CNT_WIDTH-1:0] p_act_q, h_act_q, p_sh_q, h_sh_q;
      logic [CNT_WIDTH-1:0] pe, he;
      logic                 pending_q, wave_q, wave_d, tick_q, tick_d;
      logic                 wrap, xfer, apply;

      assign sel[gi] = (cfg.cfg_chan == CW'(gi));

      // Periods below 2 are stretched to 2; high time is clipped to the period.
      assign pe   = (p_act_q < TWO) ? TWO : p_act_q;
      assign he   = (h_act_q > pe) ? pe : h_act_q;
      assign wrap = (cnt_q == pe - ONE);

      assign cnt_d  = ch_en[gi] ? (wrap ? '0 : cnt_q + ONE) : '0;
      assign wave_d = ch_en[gi] & (cnt_q < he);
      assign tick_d = ch_en[gi] & wrap;

      // A transfer needs pending==0 and an apply needs pending==1,
      // so the two can never hit the same channel in one cycle.
      assign xfer  = cfg.cfg_valid & cfg.cfg_ready & sel[gi];
      assign apply = pending_q & (~ch_en[gi] | wrap);

      // Counter, registered outputs and shadow/active configuration update.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q     <= '0;
          wave_q    <= 1'b0;
          tick_q    <= 1'b0;
          p_act_q   <= DEF_P;
          h_act_q   <= DEF_H;
          p_sh_q    <= DEF_P;
          h_sh_q    <= DEF_H;
          pending_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          wave_q <= wave_d;
          tick_q <= tick_d;
          if (xfer) begin
            p_sh_q    <= cfg.cfg_period;
            h_sh_q    <= h_cfg;
            pending_q <= 1'b1;
          end else if (apply) begin
            p_act_q   <= p_sh_q;
            h_act_q   <= h_sh_q;
            pending_q <= 1'b0;
          end
        end
      end

      assign pending[gi]     = pending_q;
      assign wave_out[gi]    = wave_q;
      assign period_tick[gi] = tick_q;
    end
  endgenerate
endmodule

// File: doc/multi_square_wave_gen.md
# multi_square_wave_gen

Multi-channel programmable square/PWM wave generator, the parametrised successor to the single-channel fixed 1 Hz divider. Produces CHANNELS independent waveforms from one system clock. Each channel has its own period and high time, loaded through a valid/ready config port and applied glitch-free at that channel's period boundary. Sits beside the clock source and feeds LED, beeper and test-pin outputs.

## Interface
- CHANNELS, 4: number of independent output channels (1..16).
- CNT_WIDTH, 24: width of period/high counters and config fields.
- DEFAULT_PERIOD, 12000000: period in clk cycles loaded at reset (1 Hz at 12 MHz).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- ch_en  input  CHANNELS  per-channel run enable.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write can be accepted.
- cfg_chan  input  max(1,$clog2(CHANNELS))  target channel.
- cfg_period  input  CNT_WIDTH  period P in clk cycles.
- cfg_high  input  CNT_WIDTH  high time H in clk cycles.
- wave_out  output  CHANNELS  registered waveform per channel.
- period_tick  output  CHANNELS  one-cycle pulse per completed period.

## Operation
- Per channel: counter cnt, active regs (P_act, H_act), shadow regs (P_sh, H_sh), pending flag.
- Reset (rst=1 at an edge): cnt=0, P_act=P_sh=DEFAULT_PERIOD, H_act=H_sh=DEFAULT_PERIOD>>1, pending=0, wave_out=0, period_tick=0. cfg_ready reads 1 after reset. Reset overrides any config transfer or enable in the same cycle.
- Effective period Pe = max(P_act, 2). Effective high He = min(H_act, Pe).
- Channel disabled (ch_en[i]=0): cnt<=0, wave_out[i]<=0, period_tick[i]<=0.
- Channel enabled: cnt<=(cnt==Pe-1)?0:cnt+1; wave_out[i]<=(cnt<He); period_tick[i]<=(cnt==Pe-1).
- H=0 gives constant low; H>=Pe gives constant high; period_tick still pulses every Pe cycles.
- Config handshake: cfg_ready = !pending[cfg_chan] (combinational from cfg_chan). Transfer occurs at an edge with cfg_valid && cfg_ready: P_sh<=cfg_period, H_sh<=cfg_high, pending<=1.
- cfg_chan >= CHANNELS: cfg_ready=1, transfer completes, data discarded.
- Apply: on an edge where pending=1 and (channel disabled, or enabled with cnt==Pe-1): P_act<=P_sh, H_act<=H_sh, pending<=0. New values govern from cnt=0 onward; a period in progress always finishes with old values.
- A transfer and an apply never coincide on one channel (transfer requires pending=0). Transfers to other channels are unaffected by any channel's apply.
- Counter arithmetic unsigned, CNT_WIDTH bits, no overflow, since cnt < Pe <= 2^CNT_WIDTH-1.

## Timing
- ch_en[i] rises, sampled at edge k: wave_out[i]=1 after edge k (if He>0). High for He edges, low for Pe-He edges.
- First period_tick[i] is high after edge k+Pe-1, for one cycle. Aligned with the last low cycle of each period.
- ch_en falls, sampled at edge k: wave_out=0 and cnt=0 after edge k.
- Config accepted at edge k on an enabled channel: applied at the first wrap edge >= k+1. Disabled channel: applied at edge k+1. cfg_ready for that channel is low in between.
- All outputs except cfg_ready are registered; no combinational path from inputs to wave_out/period_tick.

## Configuration
- WAVE_DUTY_EN defined: H_sh taken from cfg_high; arbitrary duty cycle.
- WAVE_DUTY_EN undefined: cfg_high ignored; H_sh<=cfg_period>>1 on transfer (50% duty, low half gets the extra cycle for odd P). Ports unchanged; H registers may be optimised away.

## Test plan
- DEFAULT_PERIOD=10, CHANNELS=4, rst 2 cycles, ch_en=4'b0001 -> ch0 wave 5 high/5 low repeating, period_tick every 10 cycles, other channels 0.
- WAVE_DUTY_EN, ch1 write P=8,H=3 while running -> cfg_ready[ch1] low until wrap; old 10-cycle period completes, then 3 high/5 low.
- Second write to ch1 while pending -> cfg_ready=0, held until apply, then accepted. Concurrent ch2 write accepted immediately.
- Edge values: P=0 and P=1 -> period 2; H=0 -> constant low; H=20 with P=8 -> constant high. period_tick each every Pe cycles.
- rst asserted mid-period with pending config -> after reset, all outputs 0, pending cleared, defaults restored.
- WAVE_DUTY_EN undefined, P=7,H=1 -> 3 high/4 low.
